// File: rtl/jtframe_sdram_arb_pkg.sv
// jtframe_sdram_arb_pkg: FSM encoding and one-hot priority pick shared by the SDRAM bank arbiter.
package jtframe_sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} arb_st_t;
    localparam int MAXREQ = 8;
    // First set bit of req scanning upward from start, wrapping modulo n
    function automatic logic [MAXREQ-1:0] pick_first(input logic [MAXREQ-1:0] req, input int n,
                                                       input int start);
        logic [MAXREQ-1:0] p;
        logic [2:0] idx;
        p = '0;
        for (int k = 0; k < MAXREQ; k++) begin
            idx = 3'((start + k) % n);
            if (k < n && p == '0 && req[idx]) p[idx] = 1'b1;
        end
        return p;
    endfunction
endpackage

// File: rtl/jtframe_arb_pick.sv
// jtframe_arb_pick: combinational one-hot picker, search begins at start and wraps.
module jtframe_arb_pick import jtframe_sdram_arb_pkg::*; #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   start,
    output logic [NREQ-1:0] pick
);
    assign pick = NREQ'(pick_first(MAXREQ'(req), NREQ, int'(start)));
endmodule

// File: rtl/jtframe_sdram_bank_arb.sv
// jtframe_sdram_bank_arb: shares one SDRAM read port among NREQ slot-manager requesters.
// Define JTFRAME_SDRAM_ARB_RR_EN for round-robin arbitration instead of fixed lowest-index priority.
module jtframe_sdram_bank_arb import jtframe_sdram_arb_pkg::*; #(
    parameter int SDRAMW = 22,
    parameter int NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        rq_req,
    input  logic [NREQ*SDRAMW-1:0] rq_addr,
    output logic [NREQ-1:0]        rq_ack,
    output logic [NREQ-1:0]        rq_rdy,
    output logic [31:0]            rq_data,
    output logic                   sdram_req,
    output logic [SDRAMW-1:0]      sdram_addr,
    input  logic                   sdram_ack,
    input  logic                   data_rdy,
    input  logic [31:0]            data_read,
    output logic                   busy
);
    localparam int PW = $clog2(NREQ);

    arb_st_t           st, st_nx;
    logic [NREQ-1:0]   grant, winner;
    logic [SDRAMW-1:0] win_addr;
    logic [PW-1:0]     start;
    logic              done, take;

    assign take = (st == IDLE) && |rq_req;

`ifdef JTFRAME_SDRAM_ARB_RR_EN
    logic [PW-1:0] last, win_idx;
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) if (winner[i]) win_idx = PW'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= PW'(NREQ - 1);
        else if (take) last <= win_idx;
    end
    assign start = (last == PW'(NREQ - 1)) ? '0 : last + 1'b1;
`else
    assign start = '0;
`endif

    jtframe_arb_pick #(.NREQ(NREQ)) u_pick (.req(rq_req), .start(start), .pick(winner));

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) win_addr |= winner[i] ? rq_addr[i*SDRAMW +: SDRAMW] : '0;
    end

    // Read data may arrive together with the ack; the transaction then ends straight from REQ
    assign done  = data_rdy && ((st == WAIT) || (st == REQ && sdram_ack));
    assign st_nx = (st == IDLE) ? (|rq_req ? REQ : IDLE) :
                   done ? IDLE :
                   (st == REQ && sdram_ack) ? WAIT : st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            grant      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            st <= st_nx;
            if (take) begin
                grant      <= winner;
                sdram_addr <= win_addr;
                sdram_req  <= 1'b1;
            end
            if (st == REQ && sdram_ack) sdram_req <= 1'b0;
            if (done) grant <= '0;
        end
    end

    assign rq_ack  = grant & {NREQ{sdram_ack}};
    assign rq_rdy  = grant & {NREQ{done}};
    assign rq_data = data_read;
    assign busy    = st != IDLE;
endmodule

// File: tb/tb_jtframe_sdram_bank_arb.sv
// tb_jtframe_sdram_bank_arb: randomized transaction-level check of the SDRAM bank arbiter.
module tb_jtframe_sdram_bank_arb;
    localparam int SW = 22;
    localparam int N  = 4;

    logic            clk = 0, rst;
    logic [N-1:0]    rq_req, rq_ack, rq_rdy;
    logic [N*SW-1:0] rq_addr;
    logic [31:0]     rq_data, data_read;
    logic            sdram_req, sdram_ack, data_rdy, busy;
    logic [SW-1:0]   sdram_addr;

    jtframe_sdram_bank_arb #(.SDRAMW(SW), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .rq_req(rq_req), .rq_addr(rq_addr), .rq_ack(rq_ack),
        .rq_rdy(rq_rdy), .rq_data(rq_data), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read), .busy(busy)
    );

    always #5 clk = ~clk;

    int            checks = 0, failures = 0;
    logic [SW-1:0] addr[N];
    logic [N-1:0]  pend, cool;
    int            last;
    int            order[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
`ifdef JTFRAME_SDRAM_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    task automatic drive_req(input logic [N-1:0] m);
        rq_req = m;
        for (int i = 0; i < N; i++) rq_addr[i*SW +: SW] = addr[i];
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
        last = N - 1;
    endtask

    // One full transaction starting from IDLE at a negedge with pend & ~cool nonzero
    task automatic txn(input bit hold, input bit drop, input bit same, input bit spur,
                       input int d, input int r, input logic [31:0] dv);
        int w;
        logic [N-1:0] oh;
        w  = model_pick(pend & ~cool);
        oh = N'(1) << w;
        drive_req(pend & ~cool);
        data_rdy = spur;
        #1;
        if (spur) check("spur_idle_rdy", rq_rdy, 0);
        @(negedge clk);
        data_rdy = 0;
        cool = '0;
        drive_req(pend);
        check("grant_req", sdram_req, 1);
        check("grant_addr", sdram_addr, addr[w]);
        check("grant_busy", busy, 1);
        for (int k = 0; k < d; k++) begin
            if (spur) begin
                data_rdy = 1;
                #1 check("spur_req_rdy", rq_rdy, 0);
            end
            @(negedge clk);
            data_rdy = 0;
            if (drop && k == 0) begin
                pend[w] = 0;
                drive_req(pend);
            end
            check("req_held", sdram_req, 1);
            check("req_busy", busy, 1);
        end
        sdram_ack = 1;
        data_rdy  = same;
        data_read = dv;
        #1;
        check("ack", rq_ack, oh);
        check("ack_addr", sdram_addr, addr[w]);
        check("ack_rdy", rq_rdy, same ? oh : '0);
        if (same) check("ack_data", rq_data, dv);
        @(negedge clk);
        sdram_ack = 0;
        data_rdy  = 0;
        if (hold) cool = oh;
        else pend[w] = 0;
        drive_req(pend & ~cool);
        if (!same) begin
            check("wait_req", sdram_req, 0);
            for (int k = 0; k < r; k++) begin
                check("wait_busy", busy, 1);
                @(negedge clk);
            end
            data_rdy  = 1;
            data_read = dv;
            #1;
            check("rdy", rq_rdy, oh);
            check("rdy_data", rq_data, dv);
            @(negedge clk);
            data_rdy = 0;
        end
        check("idle_busy", busy, 0);
        check("idle_req", sdram_req, 0);
        last = w;
        order.push_back(w);
    endtask

    initial begin
        int exp_order[6];
        logic [N-1:0] add;
        bit dr;
`ifdef JTFRAME_SDRAM_ARB_RR_EN
        exp_order = '{0, 1, 3, 0, 1, 3};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        rst = 1; rq_req = '0; rq_addr = '0; sdram_ack = 1; data_rdy = 1; data_read = '0;
        pend = '0; cool = '0; last = N - 1;
        for (int i = 0; i < N; i++) addr[i] = '0;
        @(negedge clk); @(negedge clk);
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", rq_ack, 0);
        check("rst_rdy", rq_rdy, 0);
        sdram_ack = 0; data_rdy = 0;
        rst = 0;
        @(negedge clk);

        pend = 4'b0100; addr[2] = 22'h1234;
        txn(0, 0, 0, 0, 2, 2, 32'hCAFEBABE);

        do_reset();
        order.delete();
        pend = 4'b1011;
        for (int i = 0; i < N; i++) addr[i] = SW'(22'h100 + i);
        for (int t = 0; t < 6; t++) txn(1, 0, 0, 0, $urandom % 3, $urandom % 3, $urandom);
        for (int t = 0; t < 6; t++) check($sformatf("order%0d", t), order[t], exp_order[t]);
        pend = '0; cool = '0; drive_req('0);

        pend = 4'b0010; addr[1] = 22'h2AAAA;
        txn(0, 0, 1, 0, 1, 0, 32'h5A5A1234);

        drive_req('0);
        data_rdy = 1; sdram_ack = 1;
        #1;
        check("idle_spur_rdy", rq_rdy, 0);
        check("idle_spur_ack", rq_ack, 0);
        @(negedge clk);
        data_rdy = 0; sdram_ack = 0;
        check("idle_spur_busy", busy, 0);
        check("idle_spur_req", sdram_req, 0);

        pend = 4'b1000; addr[3] = 22'h3F00F;
        txn(0, 0, 0, 1, 3, 1, 32'h0BADF00D);

        pend = 4'b0010; addr[1] = 22'h15555;
        txn(0, 1, 0, 0, 3, 2, 32'h12345678);

        pend = 4'b0001; addr[0] = 22'h00ABC;
        drive_req(pend);
        @(negedge clk);
        sdram_ack = 1;
        @(negedge clk);
        sdram_ack = 0;
        check("wait_pre_rst", busy, 1);
        rst = 1; sdram_ack = 1; data_rdy = 1;
        #1;
        check("mid_rst_req", sdram_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", rq_ack, 0);
        check("mid_rst_rdy", rq_rdy, 0);
        @(negedge clk);
        rst = 0; sdram_ack = 0; data_rdy = 0;
        pend = '0; last = N - 1;
        drive_req('0);
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            add = N'($urandom);
            for (int i = 0; i < N; i++) if (add[i] && !pend[i]) begin
                pend[i] = 1;
                addr[i] = SW'($urandom);
            end
            if (pend == '0) begin
                pend[0] = 1;
                addr[0] = SW'($urandom);
            end
            dr = ($urandom % 4) == 0;
            txn(0, dr, ($urandom % 4) == 0, ($urandom % 3) == 0,
                dr ? 1 + $urandom % 3 : $urandom % 4, $urandom % 4, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
